mem_responder: RTL and testbench

//  Backing-memory responder: the memory-side end of the cache controller's fill/write-back path.

---
 rtl/mem_responder_pkg.sv | 29 ++
 rtl/mem_array.sv | 37 +++
 rtl/mem_responder.sv | 176 +++++++++++++++++
 tb/tb_mem_responder.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared types and sizing helpers for the backing-memory responder.
package mem_if_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT     = 3'd1,
    ST_RD_BURST = 3'd2,
    ST_WR_BURST = 3'd3,
    ST_WR_ACK   = 3'd4
  } mem_rsp_state_t;

  // Beat counter width; a single-beat line still needs one bit to hold beat 0.
  function automatic int unsigned beat_bits(input int unsigned line_words);
    return (line_words > 1) ? $clog2(line_words) : 1;
  endfunction

  // Delay counter width; MEM_DELAY=0 keeps a 1-bit counter that is never used.
  function automatic int unsigned delay_bits(input int unsigned mem_delay);
    return (mem_delay > 0) ? $clog2(mem_delay + 1) : 1;
  endfunction

  function automatic bit line_words_ok(input int unsigned line_words,
                                       input int unsigned addr_bits);
    return (line_words >= 1) &&
           ((line_words & (line_words - 1)) == 0) &&
           (line_words <= (2 ** addr_bits));
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port word memory: synchronous write, asynchronous read.
// Every word powers up holding its own index; reset never touches contents.
module mem_array #(
  parameter int unsigned WORD_SIZE = 32,
  parameter int unsigned ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [WORD_SIZE-1:0] wdata,
  output logic [WORD_SIZE-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_BITS;

  typedef logic [WORD_SIZE-1:0] mem_t [DEPTH];

  function automatic mem_t index_image();
    mem_t img;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      img[i] = WORD_SIZE'(i);
    end
    return img;
  endfunction

  logic [WORD_SIZE-1:0] mem_q [DEPTH] = index_image();

  // Commit one word per enabled edge.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for line fills and write-backs: one request at a
// time, fixed access delay, then a read burst or an absorbed write burst.
module mem_responder
  import mem_if_pkg::*;
#(
  parameter int unsigned WORD_SIZE  = 32,
  parameter int unsigned ADDR_BITS  = 8,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned MEM_DELAY  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_wr,
  input  logic [WORD_SIZE-1:0] req_addr,
  input  logic                 wdata_valid,
  input  logic [WORD_SIZE-1:0] wdata,
  output logic                 rsp_valid,
  output logic [WORD_SIZE-1:0] rsp_data,
  output logic                 rsp_last,
  output logic                 wr_done
);

  localparam int unsigned BB = beat_bits(LINE_WORDS);
  localparam int unsigned DB = delay_bits(MEM_DELAY);
  localparam logic [ADDR_BITS-1:0] LINE_MASK = ADDR_BITS'(LINE_WORDS - 1);
  localparam logic [BB-1:0] LAST_BEAT = BB'(LINE_WORDS - 1);
  localparam logic [DB-1:0] LAST_DLY  = DB'((MEM_DELAY > 0) ? MEM_DELAY - 1 : 0);

  if (!line_words_ok(LINE_WORDS, ADDR_BITS)) begin : g_bad_line_words
    $error("mem_responder: LINE_WORDS must be a power of two in [1, 2**ADDR_BITS]");
  end

  // Address bits above the word index are deliberately ignored.
  if (WORD_SIZE > ADDR_BITS) begin : g_unused_addr
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[WORD_SIZE-1:ADDR_BITS];
  end

  mem_rsp_state_t       state_q, state_d;
  logic [ADDR_BITS-1:0] base_q, base_d;
  logic                 wr_q, wr_d;
  logic [BB-1:0]        beat_q, beat_d;
  logic [DB-1:0]        dly_q, dly_d;

  logic                 req_ready_q, req_ready_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [WORD_SIZE-1:0] rsp_data_q, rsp_data_d;
  logic                 rsp_last_q, rsp_last_d;
  logic                 wr_done_q, wr_done_d;

  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [WORD_SIZE-1:0] mem_rdata;

  mem_array #(
    .WORD_SIZE (WORD_SIZE),
    .ADDR_BITS (ADDR_BITS)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (wdata),
    .rdata (mem_rdata)
  );

  // Next-state, counter and memory-port control.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    wr_d    = wr_q;
    beat_d  = beat_q;
    dly_d   = dly_q;
    mem_we  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          base_d = req_addr[ADDR_BITS-1:0] & ~LINE_MASK;
          wr_d   = req_wr;
          beat_d = '0;
          dly_d  = '0;
          if (MEM_DELAY > 0) begin
            state_d = ST_WAIT;
          end else begin
            state_d = req_wr ? ST_WR_BURST : ST_RD_BURST;
          end
        end
      end
      ST_WAIT: begin
        if (dly_q == LAST_DLY) begin
          dly_d   = '0;
          state_d = wr_q ? ST_WR_BURST : ST_RD_BURST;
        end else begin
          dly_d = dly_q + 1'b1;
        end
      end
      ST_RD_BURST: begin
        if (beat_q == LAST_BEAT) begin
          beat_d  = '0;
          state_d = ST_IDLE;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      ST_WR_BURST: begin
        if (wdata_valid) begin
          mem_we = rst;
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = ST_WR_ACK;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      ST_WR_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Outputs are registered, so reads look up the word for the *next*
    // beat; a write burst uses the current beat. The two never overlap
    // because a write burst can only be followed by WR_ACK.
    if (state_q == ST_WR_BURST) begin
      mem_addr = base_q + ADDR_BITS'(beat_q);
    end else begin
      mem_addr = base_d + ADDR_BITS'(beat_d);
    end
  end

  // Output values for the coming cycle, decoded from the next state.
  always_comb begin
    req_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RD_BURST);
    rsp_last_d  = rsp_valid_d && (beat_d == LAST_BEAT);
    wr_done_d   = (state_d == ST_WR_ACK);
    rsp_data_d  = rsp_valid_d ? mem_rdata : '0;
  end

  // State, counters and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      wr_q        <= 1'b0;
      beat_q      <= '0;
      dly_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_last_q  <= 1'b0;
      wr_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      wr_q        <= wr_d;
      beat_q      <= beat_d;
      dly_q       <= dly_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_last_q  <= rsp_last_d;
      wr_done_q   <= wr_done_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_last  = rsp_last_q;
  assign wr_done   = wr_done_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: default instance (LINE_WORDS=4, MEM_DELAY=3)
// plus a single-beat, zero-delay instance, against a word-array model.
module tb_mem_responder;
  import mem_if_pkg::*;

  localparam int unsigned MD = 3;
  localparam int unsigned LW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid, req_ready, req_wr;
  logic [31:0] req_addr;
  logic        wdata_valid;
  logic [31:0] wdata;
  logic        rsp_valid, rsp_last, wr_done;
  logic [31:0] rsp_data;

  logic        s_req_valid, s_req_ready, s_req_wr;
  logic [31:0] s_req_addr;
  logic        s_wdata_valid;
  logic [31:0] s_wdata;
  logic        s_rsp_valid, s_rsp_last, s_wr_done;
  logic [31:0] s_rsp_data;

  logic [31:0] model   [256];
  logic [31:0] s_model [256];

  int n_checks = 0;
  int n_fail   = 0;

  mem_responder #(
    .WORD_SIZE (32), .ADDR_BITS (8), .LINE_WORDS (LW), .MEM_DELAY (MD)
  ) dut (
    .clk (clk), .rst (rst),
    .req_valid (req_valid), .req_ready (req_ready), .req_wr (req_wr), .req_addr (req_addr),
    .wdata_valid (wdata_valid), .wdata (wdata),
    .rsp_valid (rsp_valid), .rsp_data (rsp_data), .rsp_last (rsp_last), .wr_done (wr_done)
  );

  mem_responder #(
    .WORD_SIZE (32), .ADDR_BITS (8), .LINE_WORDS (1), .MEM_DELAY (0)
  ) dut_s (
    .clk (clk), .rst (rst),
    .req_valid (s_req_valid), .req_ready (s_req_ready), .req_wr (s_req_wr), .req_addr (s_req_addr),
    .wdata_valid (s_wdata_valid), .wdata (s_wdata),
    .rsp_valid (s_rsp_valid), .rsp_data (s_rsp_data), .rsp_last (s_rsp_last), .wr_done (s_wr_done)
  );

  task automatic wait_ready(input string tag);
    int t = 0;
    while (req_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s ready_timeout: req_ready=%b required 1", tag, req_ready);
    end
  endtask

  task automatic do_read(input logic [31:0] addr, input bit hold, input string tag);
    int base;
    logic [31:0] exp;
    base = (int'(addr % 256) / LW) * LW;
    wait_ready(tag);
    req_valid = 1'b1; req_wr = 1'b0; req_addr = addr;
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
    for (int d = 0; d < MD; d++) begin
      n_checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL %s wait%0d: rsp_valid=%b req_ready=%b required 0 0", tag, d, rsp_valid, req_ready);
      end
      @(negedge clk);
    end
    for (int b = 0; b < LW; b++) begin
      exp = model[(base + b) % 256];
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== exp || rsp_last !== (b == LW - 1) || req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL %s beat%0d: valid=%b data=%h last=%b ready=%b required 1 %h %b 0",
                 tag, b, rsp_valid, rsp_data, rsp_last, req_ready, exp, (b == LW - 1));
      end
      if (b == LW - 1) req_valid = 1'b0;
      @(negedge clk);
    end
    n_checks++;
    if (rsp_valid !== 1'b0 || rsp_last !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s end: valid=%b last=%b ready=%b required 0 0 1", tag, rsp_valid, rsp_last, req_ready);
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data [LW],
                          input int gap [LW], input string tag);
    int base;
    base = (int'(addr % 256) / LW) * LW;
    wait_ready(tag);
    req_valid = 1'b1; req_wr = 1'b1; req_addr = addr;
    wdata_valid = 1'b1; wdata = $urandom;  // stray beat while idle
    @(negedge clk);
    req_valid = 1'b0;
    for (int d = 0; d < MD; d++) begin
      wdata_valid = 1'b1; wdata = $urandom;  // beats during the wait are ignored
      n_checks++;
      if (req_ready !== 1'b0 || wr_done !== 1'b0) begin
        n_fail++;
        $display("FAIL %s wait%0d: ready=%b wr_done=%b required 0 0", tag, d, req_ready, wr_done);
      end
      @(negedge clk);
    end
    for (int b = 0; b < LW; b++) begin
      for (int g = 0; g < gap[b]; g++) begin
        wdata_valid = 1'b0; wdata = $urandom;
        n_checks++;
        if (req_ready !== 1'b0 || wr_done !== 1'b0) begin
          n_fail++;
          $display("FAIL %s gap%0d: ready=%b wr_done=%b required 0 0", tag, b, req_ready, wr_done);
        end
        @(negedge clk);
      end
      wdata_valid = 1'b1; wdata = data[b];
      n_checks++;
      if (req_ready !== 1'b0 || wr_done !== 1'b0) begin
        n_fail++;
        $display("FAIL %s beat%0d: ready=%b wr_done=%b required 0 0", tag, b, req_ready, wr_done);
      end
      @(negedge clk);
      model[(base + b) % 256] = data[b];
    end
    wdata_valid = 1'b0;
    n_checks++;
    if (wr_done !== 1'b1 || req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s ack: wr_done=%b ready=%b required 1 0", tag, wr_done, req_ready);
    end
    @(negedge clk);
    n_checks++;
    if (wr_done !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s ack_end: wr_done=%b ready=%b required 0 1", tag, wr_done, req_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== 32'h0 || rsp_last !== 1'b0 || wr_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: ready=%b valid=%b data=%h last=%b wr_done=%b required 1 0 0 0 0",
               req_ready, rsp_valid, rsp_data, rsp_last, wr_done);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read_basic();
    do_read(32'h10, 1'b0, "read_0x10");
  endtask

  task automatic test_write_gap();
    logic [31:0] d [LW];
    int g [LW];
    d = '{32'hA5A5A5A5, 32'h5A5A5A5A, 32'h12345678, 32'hDEADBEEF};
    g = '{0, 0, 0, 1};
    do_write(32'h20, d, g, "write_0x20");
    do_read(32'h22, 1'b0, "read_0x22");
    n_checks++;
    if (model[8'h23] !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL model_0x23: got %h required deadbeef", model[8'h23]);
    end
  endtask

  task automatic test_alias_hold();
    do_read(32'h1FF, 1'b1, "read_0x1ff_hold");
  endtask

  task automatic test_reset_mid_read();
    wait_ready("rst_rd");
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h40;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (MD + 2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b0 || rsp_data !== 32'h0 || rsp_last !== 1'b0 || wr_done !== 1'b0 || req_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL rst_rd cyc%0d: valid=%b data=%h last=%b wr_done=%b ready=%b required 0 0 0 0 1",
                 c, rsp_valid, rsp_data, rsp_last, wr_done, req_ready);
      end
    end
    rst = 1'b1;
    n_checks++;
    if (dut.state_q !== ST_IDLE) begin
      n_fail++;
      $display("FAIL rst_rd state: got %0d required %0d", dut.state_q, ST_IDLE);
    end
    @(negedge clk);
    do_read(32'h40, 1'b0, "read_after_rst");
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] d0, d1;
    d0 = $urandom; d1 = $urandom;
    wait_ready("rst_wr");
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h30;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (MD) @(negedge clk);
    wdata_valid = 1'b1; wdata = d0;
    @(negedge clk);
    model[8'h30] = d0;
    wdata = d1;
    @(negedge clk);
    model[8'h31] = d1;
    rst = 1'b0; wdata = $urandom;  // must not commit at the reset edge
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1 || wr_done !== 1'b0 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_wr: ready=%b wr_done=%b valid=%b required 1 0 0", req_ready, wr_done, rsp_valid);
    end
    rst = 1'b1; wdata = $urandom;  // stray beat while idle
    repeat (2) @(negedge clk);
    wdata_valid = 1'b0;
    do_read(32'h30, 1'b0, "read_0x30");
  endtask

  task automatic test_back_to_back();
    logic [31:0] d [LW];
    int g [LW];
    for (int i = 0; i < LW; i++) begin d[i] = $urandom; g[i] = 0; end
    do_read(32'h50, 1'b0, "b2b_rd0");
    do_read(32'h54, 1'b0, "b2b_rd1");
    do_write(32'h58, d, g, "b2b_wr");
    do_read(32'h5B, 1'b0, "b2b_rd2");
  endtask

  task automatic test_random();
    logic [31:0] d [LW];
    int g [LW];
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(1, 0) == 1) begin
        for (int i = 0; i < LW; i++) begin d[i] = $urandom; g[i] = $urandom_range(2, 0); end
        do_write($urandom, d, g, "rand_wr");
      end else begin
        do_read($urandom, 1'b0, "rand_rd");
      end
    end
  endtask

  task automatic test_single_beat();
    logic [31:0] a, w;
    for (int n = 0; n < 12; n++) begin
      a = (n == 0) ? 32'h10 : $urandom;
      if (n % 3 == 1) begin
        w = $urandom;
        s_req_valid = 1'b1; s_req_wr = 1'b1; s_req_addr = a;
        @(negedge clk);
        s_req_valid = 1'b0;
        s_wdata_valid = 1'b1; s_wdata = w;
        @(negedge clk);
        s_wdata_valid = 1'b0;
        s_model[a % 256] = w;
        n_checks++;
        if (s_wr_done !== 1'b1 || s_req_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL single_wr%0d: wr_done=%b ready=%b required 1 0", n, s_wr_done, s_req_ready);
        end
        @(negedge clk);
      end else begin
        n_checks++;
        if (s_req_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL single_ready%0d: ready=%b required 1", n, s_req_ready);
        end
        s_req_valid = 1'b1; s_req_wr = 1'b0; s_req_addr = a;
        @(negedge clk);
        s_req_valid = 1'b0;
        n_checks++;
        if (s_rsp_valid !== 1'b1 || s_rsp_data !== s_model[a % 256] || s_rsp_last !== 1'b1 || s_req_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL single_rd%0d: valid=%b data=%h last=%b ready=%b required 1 %h 1 0",
                   n, s_rsp_valid, s_rsp_data, s_rsp_last, s_req_ready, s_model[a % 256]);
        end
        @(negedge clk);
        n_checks++;
        if (s_rsp_valid !== 1'b0 || s_rsp_last !== 1'b0 || s_req_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL single_end%0d: valid=%b last=%b ready=%b required 0 0 1",
                   n, s_rsp_valid, s_rsp_last, s_req_ready);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      model[i]   = 32'(i);
      s_model[i] = 32'(i);
    end
    rst = 1'b0;
    req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; wdata_valid = 1'b0; wdata = '0;
    s_req_valid = 1'b0; s_req_wr = 1'b0; s_req_addr = '0; s_wdata_valid = 1'b0; s_wdata = '0;
    @(negedge clk);
    test_reset();
    test_read_basic();
    test_write_gap();
    test_alias_hold();
    test_reset_mid_read();
    test_reset_mid_write();
    test_back_to_back();
    test_random();
    test_single_beat();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
